// File: rtl/score_sseg_driver_pkg.sv
// rtl/score_sseg_driver_pkg.sv - shared digit codes, conversion states and BCD helpers
package score_sseg_driver_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 16;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } conv_state_e;

  // dp (bit 7) stays off; anything outside 0..9 shows as blank
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_sseg_driver_bin2bcd_seq.sv
// rtl/score_sseg_driver_bin2bcd_seq.sv - sequential double-dabble binary to 4-digit BCD converter
module score_sseg_driver_bin2bcd_seq
  import score_sseg_driver_pkg::*;
#(
  parameter int SCORE_W = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [SCORE_W-1:0] bin_i,
  output logic               load_o,
  output logic               busy_o,
  output logic [BCD_W-1:0]   bcd_o
);

  localparam int SR_W  = BCD_W + SCORE_W;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  conv_state_e      state_q;
  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_adj;
  logic [CNT_W-1:0] cnt_q;
  logic [BCD_W-1:0] bcd_q;
  logic             busy_q;

  always_comb begin
    sr_adj = sr_q;
    sr_adj[SR_W-1 -: BCD_W] = dabble_adjust(sr_q[SR_W-1 -: BCD_W]);
  end

  // BCD field sits at the top of the shift register; SCORE_W shifts complete it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          sr_q    <= {{BCD_W{1'b0}}, bin_i};
          cnt_q   <= CNT_W'(SCORE_W);
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          sr_q  <= sr_adj << 1;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          bcd_q   <= sr_q[SR_W-1 -: BCD_W];
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign load_o = (state_q == ST_LOAD);
  assign busy_o = busy_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/score_sseg_driver.sv
// rtl/score_sseg_driver.sv - score capture, BCD conversion and multiplexed 4-digit display scan
module score_sseg_driver
  import score_sseg_driver_pkg::*;
#(
  parameter int SCORE_W     = 10,
  parameter int REFRESH_DIV = 50000,
  parameter int STABLE_CYC  = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [SCORE_W-1:0] score_in,
  output logic [7:0]         sseg_a_to_dp,
  output logic [3:0]         sseg_an,
  output logic [BCD_W-1:0]   bcd_out,
  output logic               conv_busy
);

  localparam int RUN_W = $clog2(STABLE_CYC + 1) + 1;
  localparam logic [RUN_W-1:0] STABLE_N = RUN_W'(STABLE_CYC);
  localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RC_W-1:0] REF_LAST = RC_W'(REFRESH_DIV - 1);

  logic [SCORE_W-1:0] sync1_q, sync2_q, hist_q, accepted_q;
  logic [RUN_W-1:0]   run_q, run_d, run_len;
  logic               pending_q, accept, conv_load;

  logic [RC_W-1:0]    ref_cnt_q, ref_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         an_q, an_d;
  logic [7:0]         seg_q, seg_d;
  logic [3:0]         blank;
  logic [3:0]         nib_sel;

  // run_len counts consecutive identical synchronized samples including this one
  always_comb begin
    run_len = (sync2_q == hist_q) ? run_q + RUN_W'(1) : RUN_W'(1);
    run_d   = (run_len > STABLE_N) ? STABLE_N : run_len;
    accept  = (run_len >= STABLE_N) && (sync2_q != accepted_q);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      hist_q     <= '0;
      run_q      <= '0;
      accepted_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      sync1_q <= score_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      run_q   <= run_d;
      if (accept) begin
        accepted_q <= sync2_q;
        pending_q  <= 1'b1;
      end else if (conv_load) begin
        pending_q  <= 1'b0;
      end
    end
  end

  score_sseg_driver_bin2bcd_seq #(
    .SCORE_W(SCORE_W)
  ) u_bin2bcd (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .start_i(pending_q),
    .bin_i  (accepted_q),
    .load_o (conv_load),
    .busy_o (conv_busy),
    .bcd_o  (bcd_out)
  );

  // A digit is blank when it and all higher digits are zero; digit 0 always shows
  always_comb begin
    blank[3] = (bcd_out[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd_out[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd_out[7:4] == 4'd0);
    blank[0] = 1'b0;
  end

  always_comb begin
    ref_cnt_d = (ref_cnt_q == REF_LAST) ? '0 : ref_cnt_q + RC_W'(1);
    idx_d     = (ref_cnt_q == REF_LAST) ? idx_q + 2'd1 : idx_q;
    an_d      = (ref_cnt_d == '0) ? 4'b1111 : ~(4'b0001 << idx_d);
    nib_sel   = bcd_out[{idx_d, 2'b00} +: 4];
    seg_d     = blank[idx_d] ? SEG_BLANK : seg_decode(nib_sel);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ref_cnt_q <= '0;
      idx_q     <= '0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign sseg_an      = an_q;
  assign sseg_a_to_dp = seg_q;

endmodule

// File: tb/tb_score_sseg_driver.sv
// tb/tb_score_sseg_driver.sv - directed self-checking bench for score_sseg_driver
module tb_score_sseg_driver;

  localparam int SCORE_W = 10;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic [SCORE_W-1:0] score_in = '0;
  logic [7:0]         sseg_a_to_dp;
  logic [3:0]         sseg_an;
  logic [15:0]        bcd_out;
  logic               conv_busy;

  int nvec = 0;
  int nfail = 0;

  score_sseg_driver #(
    .SCORE_W(SCORE_W),
    .REFRESH_DIV(4),
    .STABLE_CYC(2)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .score_in    (score_in),
    .sseg_a_to_dp(sseg_a_to_dp),
    .sseg_an     (sseg_an),
    .bcd_out     (bcd_out),
    .conv_busy   (conv_busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl);
    int n;
    n = 0;
    while (conv_busy !== lvl && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic busy_width(output int w);
    w = 0;
    while (conv_busy === 1'b1 && w < 40) begin
      @(negedge sys_clk);
      w++;
    end
  endtask

  task automatic run_conv(input string tag, input logic [15:0] exp_bcd);
    int w;
    wait_busy(1'b1);
    chk({tag, " busy start"}, 32'(conv_busy), 32'd1);
    busy_width(w);
    chk({tag, " busy width"}, w, 12);
    chk({tag, " bcd"}, 32'(bcd_out), 32'(exp_bcd));
  endtask

  task automatic scan_check(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [3:0] seen;
    seen = '0;
    repeat (20) begin
      @(negedge sys_clk);
      case (sseg_an)
        4'b1110: begin chk({tag, " d0"}, 32'(sseg_a_to_dp), 32'(e0)); seen[0] = 1'b1; end
        4'b1101: begin chk({tag, " d1"}, 32'(sseg_a_to_dp), 32'(e1)); seen[1] = 1'b1; end
        4'b1011: begin chk({tag, " d2"}, 32'(sseg_a_to_dp), 32'(e2)); seen[2] = 1'b1; end
        4'b0111: begin chk({tag, " d3"}, 32'(sseg_a_to_dp), 32'(e3)); seen[3] = 1'b1; end
        4'b1111: ;
        default: chk({tag, " anode onehot"}, 32'(sseg_an), 32'hF);
      endcase
    end
    chk({tag, " digits seen"}, 32'(seen), 32'hF);
  endtask

  initial begin
    logic [3:0] an_exp [10];
    int w;
    int idle;
    int nb;
    an_exp = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111,
               4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1011};

    // reset state
    repeat (3) @(negedge sys_clk);
    chk("rst an", 32'(sseg_an), 32'hF);
    chk("rst seg", 32'(sseg_a_to_dp), 32'hFF);
    chk("rst bcd", 32'(bcd_out), 32'h0);
    chk("rst busy", 32'(conv_busy), 32'h0);
    sys_rst_n = 1'b1;

    // score 0: no conversion, only digit 0 lit
    scan_check("zero", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
    chk("zero busy", 32'(conv_busy), 32'h0);
    chk("zero bcd", 32'(bcd_out), 32'h0);

    score_in = 10'd123;
    run_conv("s123", 16'h0123);
    scan_check("s123", 8'hB0, 8'hA4, 8'hF9, 8'hFF);

    score_in = 10'd1023;
    run_conv("s1023", 16'h1023);
    scan_check("s1023", 8'hB0, 8'hA4, 8'hC0, 8'hF9);

    // new score lands mid-conversion: finishes 5, one IDLE cycle, then converts 7
    score_in = 10'd5;
    wait_busy(1'b1);
    chk("s5 busy start", 32'(conv_busy), 32'd1);
    score_in = 10'd7;
    busy_width(w);
    chk("s5 busy width", w, 12);
    chk("s5 bcd", 32'(bcd_out), 32'h0005);
    idle = 0;
    while (conv_busy !== 1'b1 && idle < 30) begin
      @(negedge sys_clk);
      idle++;
    end
    chk("b2b idle cycles", idle, 1);
    busy_width(w);
    chk("s7 busy width", w, 12);
    chk("s7 bcd", 32'(bcd_out), 32'h0007);

    // single-cycle glitch is filtered out
    score_in = 10'd42;
    run_conv("s42", 16'h0042);
    @(negedge sys_clk);
    score_in = 10'd999;
    @(negedge sys_clk);
    score_in = 10'd42;
    nb = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (conv_busy === 1'b1) nb++;
    end
    chk("glitch busy cycles", nb, 0);
    chk("glitch bcd", 32'(bcd_out), 32'h0042);

    // reset during SHIFT
    score_in = 10'd100;
    wait_busy(1'b1);
    chk("s100 busy start", 32'(conv_busy), 32'd1);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst an", 32'(sseg_an), 32'hF);
    chk("midrst seg", 32'(sseg_a_to_dp), 32'hFF);
    chk("midrst bcd", 32'(bcd_out), 32'h0);
    chk("midrst busy", 32'(conv_busy), 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    chk("an seq 0", 32'(sseg_an), 32'(an_exp[0]));
    for (int k = 1; k < 10; k++) begin
      @(negedge sys_clk);
      chk($sformatf("an seq %0d", k), 32'(sseg_an), 32'(an_exp[k]));
    end
    wait_busy(1'b0);
    chk("restart bcd", 32'(bcd_out), 32'h0100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
